vend_ctrl: RTL
==============

VEND_CTRL -- requirements
Module: vend_ctrl

Interface
REQ-001 SHALL have parameter N_SLOTS, default 4: number of product slots.
REQ-002 SHALL have parameter PRICE_N, default 10: price in nickel units (10 = 50c).
REQ-003 SHALL have parameter CNT_W, default 8: width of can and coin reserve counters.
REQ-004 SHALL have parameter CR_W, default 6: credit width in nickel units; SLOT_W = clog2(N_SLOTS).
REQ-005 SHALL have ports, clock and reset first; one clock; reset is asynchronous and active-high:
- CLK  in  1  clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- LOAD_COINS  in  1  add NICKELS/DIMES to reserve.
- LOAD_CANS  in  1  add CANS to slot LOAD_SLOT.
- LOAD_SLOT  in  SLOT_W  slot to load.
- NICKELS, DIMES, CANS  in  CNT_W  load amounts.
- NICKEL_IN, DIME_IN, QUARTER_IN  in  1  coin strobes.
- SELECT  in  1  vend request for slot SLOT.
- SLOT  in  SLOT_W  requested slot.
- CANCEL  in  1  refund request.
- EMPTY  out  N_SLOTS  bit i = slot i count is 0.
- DISPENSE  out  1  one-cycle vend pulse.
- DISPENSE_SLOT  out  SLOT_W  slot vended.
- NICKEL_OUT, DIME_OUT  out  1  one-coin-per-cycle change pulses.
- CHANGE_BUSY  out  1  payout in progress.
- USE_EXACT  out  1  reserve low.
- CREDIT  out  CR_W  current credit, nickel units.

Function
REQ-006 SHALL implement states IDLE, VEND, PAYOUT; all inputs other than RST are ignored outside IDLE.
REQ-007 In IDLE, per-edge precedence SHALL be: load > CANCEL > SELECT > coin; one action per edge, lower-priority requests dropped.
REQ-008 Coins: value nickel 1, dime 2, quarter 5; with simultaneous strobes only the highest value is accepted; CREDIT updates on the sampling edge.
REQ-009 An accepted nickel/dime SHALL also increment its reserve counter; quarters are not stored as change.
REQ-010 A coin that would push CREDIT beyond 2^CR_W-1 SHALL be ignored.
REQ-011 Loads SHALL add to the counters, saturating at 2^CNT_W-1.
REQ-012 "Payable(c)": with d = min(c/2, dimes), c - 2d <= nickels.
REQ-013 SELECT SHALL be accepted iff CREDIT >= PRICE_N, slot count > 0 and Payable(CREDIT-PRICE_N); otherwise ignored with no state change.
REQ-014 On acceptance: next state VEND, DISPENSE=1 and DISPENSE_SLOT=SLOT for exactly that cycle, slot count decremented, CREDIT -= PRICE_N.
REQ-015 From VEND: PAYOUT if CREDIT>0, else IDLE.
REQ-016 CANCEL SHALL be accepted iff CREDIT>0 and Payable(CREDIT); it enters PAYOUT directly.
REQ-017 PAYOUT, each cycle:
- if CREDIT>=2 and dimes>0: DIME_OUT=1, CREDIT-=2, dimes-1;
- else NICKEL_OUT=1, CREDIT-=1, nickels-1.
- Return to IDLE the cycle after CREDIT reaches 0.
REQ-018 CHANGE_BUSY SHALL be 1 exactly while in PAYOUT.
REQ-019 DISPENSE, NICKEL_OUT, DIME_OUT SHALL be registered; never both coin pulses in one cycle.
REQ-020 EMPTY SHALL be combinational from the slot counters.
REQ-021 USE_EXACT SHALL be combinational: (nickels < 1) or (dimes < 2).

Reset
REQ-022 RST SHALL asynchronously clear state to IDLE and clear all counters, CREDIT and pulses to 0; EMPTY all ones; USE_EXACT 1.
REQ-023 RST mid-VEND or mid-PAYOUT SHALL abort the operation; undelivered change is lost.

Structure
REQ-024 Package vend_pkg SHALL hold the state enum and the coin value constants (1/2/5).
REQ-025 Sub-module vend_change_chk SHALL compute Payable(c) combinationally; it is instantiated twice (vend check and cancel check).

Verification
REQ-026 Reset -> EMPTY=4'b1111, USE_EXACT=1, CREDIT=0, CHANGE_BUSY=0.
REQ-027 Load 1 can into slot 2; Q, Q; SELECT slot 2 -> one DISPENSE with DISPENSE_SLOT=2; EMPTY[2]=1; CREDIT=0; no coin pulses.
REQ-028 Coins 1,2; 1 can in slot 0; D, D, D, Q; SELECT 0 -> DISPENSE, then one NICKEL_OUT; USE_EXACT=1 afterwards.
REQ-029 Coins 2,3; Q, Q, Q; SELECT -> DISPENSE, then DIME_OUT, DIME_OUT, NICKEL_OUT on consecutive cycles; CHANGE_BUSY=1 for 3 cycles.
REQ-030 Coins 0,0; D, N; CANCEL -> DIME_OUT then NICKEL_OUT; CREDIT=0.
REQ-031 Edge cases:
- DIME_IN+QUARTER_IN on the same edge -> CREDIT += 5.
- SELECT on an empty slot, or with credit < price, is ignored.
- RST during PAYOUT -> immediate IDLE, no further pulses.

Source files
------------

// File: rtl/vend_pkg.sv
// Shared types for the vending controller.
// FSM states and coin values in nickel units.
package vend_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_VEND,
        ST_PAYOUT
    } state_t;

    localparam int unsigned NICKEL_VAL  = 1;
    localparam int unsigned DIME_VAL    = 2;
    localparam int unsigned QUARTER_VAL = 5;

endpackage

// File: rtl/vend_change_chk.sv
// Decides whether an amount can be returned from the coin reserve,
// using as many dimes as possible and nickels for the remainder.
module vend_change_chk #(
    parameter int CR_W  = 6,
    parameter int CNT_W = 8
) (
    input  logic [CR_W-1:0]  credit,
    input  logic [CNT_W-1:0] nickels,
    input  logic [CNT_W-1:0] dimes,
    output logic             payable
);

    localparam int W = ((CR_W > CNT_W) ? CR_W : CNT_W) + 1;

    logic [W-1:0] half;
    logic [W-1:0] dimes_w;
    logic [W-1:0] use_d;
    logic [W-1:0] rem;

    assign half    = W'(credit >> 1);
    assign dimes_w = W'(dimes);
    assign use_d   = (half < dimes_w) ? half : dimes_w;
    // 2*use_d never exceeds credit, so no underflow here
    assign rem     = W'(credit) - (use_d << 1);
    assign payable = (rem <= W'(nickels));

endmodule

// File: rtl/vend_ctrl.sv
// Vending machine controller: credit, can stock, coin reserve
// and one-coin-per-cycle change payout.
module vend_ctrl
    import vend_pkg::*;
#(
    parameter int N_SLOTS = 4,
    parameter int PRICE_N = 10,
    parameter int CNT_W   = 8,
    parameter int CR_W    = 6,
    parameter int SLOT_W  = $clog2(N_SLOTS)
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              LOAD_COINS,
    input  logic              LOAD_CANS,
    input  logic [SLOT_W-1:0] LOAD_SLOT,
    input  logic [CNT_W-1:0]  NICKELS,
    input  logic [CNT_W-1:0]  DIMES,
    input  logic [CNT_W-1:0]  CANS,
    input  logic              NICKEL_IN,
    input  logic              DIME_IN,
    input  logic              QUARTER_IN,
    input  logic              SELECT,
    input  logic [SLOT_W-1:0] SLOT,
    input  logic              CANCEL,
    output logic [N_SLOTS-1:0] EMPTY,
    output logic              DISPENSE,
    output logic [SLOT_W-1:0] DISPENSE_SLOT,
    output logic              NICKEL_OUT,
    output logic              DIME_OUT,
    output logic              CHANGE_BUSY,
    output logic              USE_EXACT,
    output logic [CR_W-1:0]   CREDIT
);

    localparam int SW = CR_W + 3;
    localparam logic [CR_W-1:0]  CR_PRICE = CR_W'(PRICE_N);
    localparam logic [CR_W-1:0]  CR_NICK  = CR_W'(NICKEL_VAL);
    localparam logic [CR_W-1:0]  CR_DIME  = CR_W'(DIME_VAL);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_TWO  = CNT_W'(2);
    localparam logic [SW-1:0]    SUM_MAX  = SW'({CR_W{1'b1}});
    localparam logic [SLOT_W:0]  SLOT_LIM = (SLOT_W + 1)'(N_SLOTS);

    state_t           state;
    logic [CNT_W-1:0] nickels_q;
    logic [CNT_W-1:0] dimes_q;
    logic [CNT_W-1:0] cans_q [N_SLOTS];

    logic [2:0]      coin_val;
    logic [SW-1:0]   coin_sum;
    logic            coin_ok;
    logic [CR_W-1:0] vend_rem;
    logic            vend_pay;
    logic            cancel_pay;
    logic            vend_ok;
    logic            cancel_ok;
    logic            sel_in_range;
    logic            load_in_range;

    function automatic logic [CNT_W-1:0] sat_add(
        input logic [CNT_W-1:0] a,
        input logic [CNT_W-1:0] b
    );
        logic [CNT_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
    endfunction

    // Highest-value strobe wins when several arrive together
    always_comb begin
        coin_val = 3'd0;
        if (QUARTER_IN)
            coin_val = 3'(QUARTER_VAL);
        else if (DIME_IN)
            coin_val = 3'(DIME_VAL);
        else if (NICKEL_IN)
            coin_val = 3'(NICKEL_VAL);
    end

    assign coin_sum = SW'(CREDIT) + SW'(coin_val);
    assign coin_ok  = (coin_val != 3'd0) && (coin_sum <= SUM_MAX);

    assign sel_in_range  = ({1'b0, SLOT} < SLOT_LIM);
    assign load_in_range = ({1'b0, LOAD_SLOT} < SLOT_LIM);
    assign vend_rem      = CREDIT - CR_PRICE;

    vend_change_chk #(.CR_W(CR_W), .CNT_W(CNT_W)) u_vend_chk (
        .credit  (vend_rem),
        .nickels (nickels_q),
        .dimes   (dimes_q),
        .payable (vend_pay)
    );

    vend_change_chk #(.CR_W(CR_W), .CNT_W(CNT_W)) u_cancel_chk (
        .credit  (CREDIT),
        .nickels (nickels_q),
        .dimes   (dimes_q),
        .payable (cancel_pay)
    );

    assign vend_ok = (CREDIT >= CR_PRICE) && sel_in_range
                  && (cans_q[SLOT] != '0) && vend_pay;
    assign cancel_ok = (CREDIT != '0) && cancel_pay;

    always_comb begin
        EMPTY = '0;
        for (int i = 0; i < N_SLOTS; i++)
            EMPTY[i] = (cans_q[i] == '0);
    end

    assign USE_EXACT   = (nickels_q < CNT_ONE) || (dimes_q < CNT_TWO);
    assign CHANGE_BUSY = (state == ST_PAYOUT);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state         <= ST_IDLE;
            nickels_q     <= '0;
            dimes_q       <= '0;
            CREDIT        <= '0;
            DISPENSE      <= 1'b0;
            DISPENSE_SLOT <= '0;
            NICKEL_OUT    <= 1'b0;
            DIME_OUT      <= 1'b0;
            for (int i = 0; i < N_SLOTS; i++)
                cans_q[i] <= '0;
        end else begin
            DISPENSE   <= 1'b0;
            NICKEL_OUT <= 1'b0;
            DIME_OUT   <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    // A pending request of higher rank consumes the edge
                    if (LOAD_COINS || LOAD_CANS) begin
                        if (LOAD_COINS) begin
                            nickels_q <= sat_add(nickels_q, NICKELS);
                            dimes_q   <= sat_add(dimes_q, DIMES);
                        end
                        if (LOAD_CANS && load_in_range)
                            cans_q[LOAD_SLOT] <= sat_add(cans_q[LOAD_SLOT], CANS);
                    end else if (CANCEL) begin
                        if (cancel_ok)
                            state <= ST_PAYOUT;
                    end else if (SELECT) begin
                        if (vend_ok) begin
                            state         <= ST_VEND;
                            DISPENSE      <= 1'b1;
                            DISPENSE_SLOT <= SLOT;
                            cans_q[SLOT]  <= cans_q[SLOT] - CNT_ONE;
                            CREDIT        <= vend_rem;
                        end
                    end else if (coin_ok) begin
                        CREDIT <= coin_sum[CR_W-1:0];
                        if (coin_val == 3'(NICKEL_VAL))
                            nickels_q <= sat_add(nickels_q, CNT_ONE);
                        if (coin_val == 3'(DIME_VAL))
                            dimes_q <= sat_add(dimes_q, CNT_ONE);
                    end
                end
                ST_VEND: begin
                    state <= (CREDIT != '0) ? ST_PAYOUT : ST_IDLE;
                end
                ST_PAYOUT: begin
                    if (CREDIT >= CR_DIME && dimes_q != '0) begin
                        DIME_OUT <= 1'b1;
                        CREDIT   <= CREDIT - CR_DIME;
                        dimes_q  <= dimes_q - CNT_ONE;
                        if (CREDIT == CR_DIME)
                            state <= ST_IDLE;
                    end else if (CREDIT != '0) begin
                        NICKEL_OUT <= 1'b1;
                        CREDIT     <= CREDIT - CR_NICK;
                        nickels_q  <= nickels_q - CNT_ONE;
                        if (CREDIT == CR_NICK)
                            state <= ST_IDLE;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
